// File: rtl/emg_scan_sequencer.sv
// EMG scan sequencer: steps the mux through enabled channels, fires one ADC conversion each, streams tagged results.
// Latency: sample valid 1 cycle after adc_done; per-channel period SETTLE_CYCLES+1+conversion+1 cycles.
// Backpressure: single holding register; a capture while a sample is still held drops it and sets sticky overrun.
// Optional per-channel VGA gain table: define EMG_GAIN_TABLE_EN (otherwise gain is fixed at DEFAULT_GAIN).
module emg_scan_sequencer #(
  parameter int          NUM_CH        = 16,
  parameter int          CH_W          = 4,
  parameter int          DATA_W        = 10,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          CONV_CYCLES   = 13,
  parameter logic [2:0]  DEFAULT_GAIN  = 3'b111
) (
  input  logic              CLK_EMG,
  input  logic              RESET,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              gain_wr_en,
  input  logic [CH_W-1:0]   gain_wr_ch,
  input  logic [2:0]        gain_wr_val,
  output logic [CH_W-1:0]   ch_sel,
  output logic              en_adc,
  output logic              start_conv,
  output logic [2:0]        gain,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic [CH_W-1:0]   s_ch,
  output logic              s_frame,
  output logic              overrun,
  output logic              timeout
);

  localparam int TO_CYCLES = CONV_CYCLES + 4;
  localparam int CNT_MAX   = (TO_CYCLES > SETTLE_CYCLES) ? TO_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SELECT, START, CONVERT} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   cur_ch, sel_ch, nxt_ch, low_ch;
  logic [NUM_CH-1:0] mask_lat;
  logic [CNT_W-1:0]  cnt;
  logic              first_ch, sel_first, enter_sel, latch_mask;
  logic              capture, to_fire, advance, nxt_found;

  assign ch_sel     = cur_ch;
  assign en_adc     = (state != IDLE);
  assign start_conv = (state == START);

  // Priority search: lowest channel of the live mask, next higher channel of the latched mask
  always_comb begin
    low_ch    = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) low_ch = CH_W'(i);
      if (mask_lat[i] && (CH_W'(i) > cur_ch)) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  // State register
  always_ff @(posedge CLK_EMG or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and sequencing decisions; a frame ends when no higher channel remains
  always_comb begin
    state_nxt  = state;
    enter_sel  = 1'b0;
    sel_ch     = cur_ch;
    sel_first  = 1'b0;
    latch_mask = 1'b0;
    capture    = 1'b0;
    to_fire    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && (|ch_mask)) begin
          state_nxt  = SELECT;
          enter_sel  = 1'b1;
          latch_mask = 1'b1;
          sel_ch     = low_ch;
          sel_first  = 1'b1;
        end
      end
      SELECT: begin
        if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = START;
      end
      START: begin
        state_nxt = CONVERT;
      end
      CONVERT: begin
        if (adc_done) begin
          capture = 1'b1;
          advance = 1'b1;
        end else if (cnt == CNT_W'(TO_CYCLES - 1)) begin
          to_fire = 1'b1;
          advance = 1'b1;
        end
        if (advance) begin
          if (nxt_found) begin
            if (enable) begin
              state_nxt = SELECT;
              enter_sel = 1'b1;
              sel_ch    = nxt_ch;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            latch_mask = 1'b1;
            if (enable && (|ch_mask)) begin
              state_nxt = SELECT;
              enter_sel = 1'b1;
              sel_ch    = low_ch;
              sel_first = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel, latched mask and shared settle/conversion counter
  always_ff @(posedge CLK_EMG or posedge RESET) begin
    if (RESET) begin
      cur_ch   <= '0;
      mask_lat <= '0;
      first_ch <= 1'b0;
      cnt      <= '0;
    end else begin
      if (latch_mask) mask_lat <= ch_mask;
      if (enter_sel) begin
        cur_ch   <= sel_ch;
        first_ch <= sel_first;
      end
      if (enter_sel || (state == START))            cnt <= '0;
      else if ((state == SELECT) || (state == CONVERT)) cnt <= cnt + 1'b1;
    end
  end

  // Output holding register with drop-on-full and sticky error flags
  always_ff @(posedge CLK_EMG or posedge RESET) begin
    if (RESET) begin
      s_valid <= 1'b0;
      s_data  <= '0;
      s_ch    <= '0;
      s_frame <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (capture) begin
        if (!s_valid || s_ready) begin
          s_valid <= 1'b1;
          s_data  <= adc_data;
          s_ch    <= cur_ch;
          s_frame <= first_ch;
        end else begin
          overrun <= 1'b1;
        end
      end else if (s_valid && s_ready) begin
        s_valid <= 1'b0;
      end
      if (to_fire) timeout <= 1'b1;
    end
  end

`ifdef EMG_GAIN_TABLE_EN
  logic [2:0] gain_tab [NUM_CH];
  logic [2:0] gain_q;

  // Gain table writes; the VGA gain is sampled from the table only when a channel is selected
  always_ff @(posedge CLK_EMG or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) gain_tab[i] <= DEFAULT_GAIN;
      gain_q <= DEFAULT_GAIN;
    end else begin
      if (gain_wr_en && (int'(gain_wr_ch) < NUM_CH)) gain_tab[gain_wr_ch] <= gain_wr_val;
      if (enter_sel) gain_q <= gain_tab[sel_ch];
    end
  end

  assign gain = gain_q;
`else
  logic unused_gain_wr;
  assign unused_gain_wr = ^{gain_wr_en, gain_wr_ch, gain_wr_val};
  assign gain = DEFAULT_GAIN;
`endif

endmodule

// File: tb/tb_emg_scan_sequencer.sv
// Bench for emg_scan_sequencer: random ADC data, random/directed masks and ready, channel-order reference model.
// An ADC responder answers each start pulse; expected samples go to a scoreboard drained by a stream monitor.
// Gain expectations follow EMG_GAIN_TABLE_EN when it is defined for the build.
module tb_emg_scan_sequencer;

  localparam int SETTLE = 2;
  localparam int DONE_K = 14;   // done pulse 13 full conversion clocks after the start clock
  localparam int TO_K   = 17;   // CONV_CYCLES + 4 cycles in CONVERT

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] ch_mask = '0;
  logic        adc_done = 1'b0;
  logic [9:0]  adc_data = '0;
  logic        gain_wr_en = 1'b0;
  logic [3:0]  gain_wr_ch = '0;
  logic [2:0]  gain_wr_val = '0;
  logic [3:0]  ch_sel;
  logic        en_adc, start_conv;
  logic [2:0]  gain;
  logic        s_valid;
  logic        s_ready = 1'b0;
  logic [9:0]  s_data;
  logic [3:0]  s_ch;
  logic        s_frame, overrun, timeout;

  emg_scan_sequencer dut (
    .CLK_EMG(clk), .RESET(rst), .enable(enable), .ch_mask(ch_mask),
    .adc_done(adc_done), .adc_data(adc_data),
    .gain_wr_en(gain_wr_en), .gain_wr_ch(gain_wr_ch), .gain_wr_val(gain_wr_val),
    .ch_sel(ch_sel), .en_adc(en_adc), .start_conv(start_conv), .gain(gain),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ch(s_ch), .s_frame(s_frame),
    .overrun(overrun), .timeout(timeout)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [9:0] d; logic [3:0] ch; logic fr; } samp_t;
  samp_t sb[$];

  int errors = 0;
  int checks = 0;

  // reference model state
  logic        m_active = 1'b0;
  logic [15:0] m_mask = '0;
  int          m_ch = 0;
  logic        m_first = 1'b0;
  logic        converting = 1'b0;
  int          k = 0;
  int          exp_start = 0;
  logic        m_full = 1'b0;
  logic        exp_ovr = 1'b0;
  logic        exp_to = 1'b0;
  logic        vchk = 1'b0;
  int          n_conv = 0;
  logic [2:0]  tab [16];
  int          ready_mode = 0;   // 0 random, 1 held low, 2 held high
  int          withhold_ch = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic budget_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired at cycle %0d", name, cyc);
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int next_higher(input logic [15:0] m, input int c);
    for (int i = c + 1; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_gain(input int c);
`ifdef EMG_GAIN_TABLE_EN
    return tab[c];
`else
    return 3'b111;
`endif
  endfunction

  // Channel ordering rule: next higher in the frame's mask, else new frame from the live mask
  task automatic model_advance();
    int nx;
    n_conv++;
    nx = next_higher(m_mask, m_ch);
    if (nx >= 0) begin
      if (enable) begin
        m_ch = nx; m_first = 1'b0; exp_start = cyc + SETTLE + 1;
      end else m_active = 1'b0;
    end else begin
      m_mask = ch_mask;
      if (enable && (ch_mask != 0)) begin
        m_ch = lowest(ch_mask); m_first = 1'b1; exp_start = cyc + SETTLE + 1;
      end else m_active = 1'b0;
    end
  endtask

  // ADC responder, ready driver and reference model, all evaluated on the falling edge
  initial begin : model
    logic [9:0] d;
    logic       cap;
    for (int i = 0; i < 16; i++) tab[i] = 3'b111;
    forever begin
      @(negedge clk);
      adc_done = 1'b0;
      case (ready_mode)
        1:       s_ready = 1'b0;
        2:       s_ready = 1'b1;
        default: s_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (rst) begin
        m_active = 1'b0; converting = 1'b0; m_full = 1'b0; vchk = 1'b0;
        exp_ovr = 1'b0; exp_to = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) tab[i] = 3'b111;
        continue;
      end
      if (vchk) begin
        chk("valid_after_done", s_valid, 1);
        vchk = 1'b0;
      end
      cap = 1'b0;
      if (!m_active && enable && (ch_mask != 0)) begin
        m_active = 1'b1; m_mask = ch_mask; m_ch = lowest(ch_mask); m_first = 1'b1;
        exp_start = cyc + SETTLE + 1;
      end
      if (start_conv) begin
        chk("start_expected", {31'd0, m_active && !converting}, 1);
        chk("start_cycle", cyc, exp_start);
        chk("ch_sel", ch_sel, m_ch);
        chk("gain", gain, exp_gain(m_ch));
        chk("en_adc_run", en_adc, 1);
        chk("timeout_flag", timeout, exp_to);
        chk("overrun_flag", overrun, exp_ovr);
        converting = 1'b1;
        k = 0;
      end else if (converting) begin
        k++;
        chk("ch_sel_hold", ch_sel, m_ch);
        chk("start_pulse_width", start_conv, 0);
        if (m_ch != withhold_ch && k == DONE_K) begin
          d = 10'($urandom_range(0, 1023));
          adc_done = 1'b1;
          adc_data = d;
          cap = 1'b1;
          if (m_full && !s_ready) exp_ovr = 1'b1;
          else begin
            sb.push_back('{d, 4'(m_ch), m_first});
            m_full = 1'b1;
            vchk = 1'b1;
          end
          converting = 1'b0;
          model_advance();
        end else if (m_ch == withhold_ch && k == TO_K) begin
          exp_to = 1'b1;
          converting = 1'b0;
          model_advance();
        end
      end
      if (!cap && m_full && s_ready) m_full = 1'b0;
    end
  end

  // Stream monitor: every accepted sample must match the scoreboard head
  initial begin : monitor
    samp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && s_valid && s_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_sample: ch %0d data %0h with empty scoreboard", s_ch, s_data);
        end else begin
          e = sb.pop_front();
          chk("s_data", s_data, e.d);
          chk("s_ch", s_ch, e.ch);
          chk("s_frame", s_frame, e.fr);
        end
      end
    end
  end

  task automatic drive_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_convs(input int n);
    int target;
    int t;
    target = n_conv + n;
    t = 0;
    while (n_conv < target && t < 3000) begin @(posedge clk); t++; end
    if (n_conv < target) budget_fail("wait_convs");
  endtask

  task automatic wait_ch(input int c);
    int t;
    t = 0;
    while (!(converting && m_ch == c) && t < 3000) begin @(posedge clk); t++; end
    if (!(converting && m_ch == c)) budget_fail("wait_ch");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_active || converting) && t < 3000) begin @(posedge clk); t++; end
    if (m_active || converting) budget_fail("wait_idle");
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin : main
    int t;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ch_sel", ch_sel, 0);
    chk("rst_en_adc", en_adc, 0);
    chk("rst_start_conv", start_conv, 0);
    chk("rst_gain", gain, 3'b111);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_data", s_data, 0);
    chk("rst_s_ch", s_ch, 0);
    chk("rst_s_frame", s_frame, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    drive_slot(); rst = 1'b0;

    // full mask, one complete frame plus wrap
    drive_slot(); ch_mask = 16'hFFFF; enable = 1'b1;
    wait_convs(18);

    // sparse mask, then a mid-frame change that must wait for the frame end
    drive_slot(); ch_mask = 16'h8011;
    wait_convs(22);
    wait_ch(4);
    drive_slot(); ch_mask = 16'h0002;
    wait_convs(4);

    // random masks
    for (int r = 0; r < 4; r++) begin
      drive_slot(); ch_mask = 16'($urandom_range(1, 16'hFFFF));
      wait_convs(20);
    end

    // backpressure: hold two samples' worth, expect drop of the second
    drive_slot(); ready_mode = 2; ch_mask = 16'h00FF;
    wait_convs(1);
    drive_slot(); ready_mode = 1;
    wait_convs(2);
    drive_slot();
    chk("overrun_set", overrun, 1);
    chk("held_valid", s_valid, 1);
    chk("held_count", sb.size(), 1);
    ready_mode = 2;
    repeat (3) @(posedge clk);
    chk("held_drained", sb.size(), 0);

    // withheld done on channel 3
    drive_slot(); ch_mask = 16'h001F; withhold_ch = 3;
    t = 0;
    while (!exp_to && t < 3000) begin @(posedge clk); t++; end
    if (!exp_to) budget_fail("wait_timeout");
    wait_convs(2);
    drive_slot(); withhold_ch = -1;
    chk("timeout_set", timeout, 1);
    ready_mode = 0;

    // gain table write while idle
    drive_slot(); enable = 1'b0;
    wait_idle();
    chk("idle_en_adc", en_adc, 0);
    drive_slot(); gain_wr_en = 1'b1; gain_wr_ch = 4'd2; gain_wr_val = 3'b010; tab[2] = 3'b010;
    drive_slot(); gain_wr_en = 1'b0;
    drive_slot(); ch_mask = 16'h000F; enable = 1'b1;
    wait_convs(8);

    // enable falls during a conversion: that sample still arrives, then idle
    drive_slot(); ch_mask = 16'hFFFF;
    wait_ch(5);
    drive_slot(); enable = 1'b0;
    wait_idle();
    chk("stop_en_adc", en_adc, 0);

    // reset during a conversion
    drive_slot(); enable = 1'b1;
    wait_ch(7);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en_adc", en_adc, 0);
    chk("mid_rst_s_valid", s_valid, 0);
    chk("mid_rst_ch_sel", ch_sel, 0);
    chk("mid_rst_start", start_conv, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_gain", gain, 3'b111);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_convs(3);

    // drain
    drive_slot(); ready_mode = 2; enable = 1'b0;
    wait_idle();
    t = 0;
    while (sb.size() != 0 && t < 100) begin @(posedge clk); t++; end
    chk("final_drain", sb.size(), 0);
    chk("final_s_valid", s_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
